// File: rtl/step_clock.sv
// -----------------------------------------------------------------------------
// step_clock
//   Tempo engine for the step sequencer. Converts a held BPM level into one
//   step_tick per sequencer step, using a phase accumulator so the average
//   step rate is exact for any BPM without a divider. Tracks the current step
//   index and the number of completed loops. A run can be bounded by Loops or
//   can run forever.
//
// Ports
//   CLOCK_50    in   1      system clock, all state on rising edge
//   reset       in   1      asynchronous, active-high reset
//   BPM         in   10     tempo (held level), clamped to MIN_BPM..MAX_BPM
//   Loops       in   7      loop count latched at start; 0 = run forever
//   Start       in   1      held level; each rising edge toggles run/stop
//   step_tick   out  1      one-cycle pulse at the start of each step
//   step_index  out  IDX_W  current step
//   loop_count  out  7      completed loops since start
//   running     out  1      high while in RUN
//   done        out  1      one-cycle pulse when the loop count is exhausted
//
// States
//   S_IDLE | stopped; waits for a Start rising edge
//   S_RUN  | accumulating phase, emitting step ticks
// -----------------------------------------------------------------------------
module step_clock #(
    parameter int CLK_HZ         = 50_000_000,
    parameter int STEPS          = 16,
    parameter int STEPS_PER_BEAT = 4,
    parameter int MIN_BPM        = 30,
    parameter int MAX_BPM        = 300
) (
    input  logic                     CLOCK_50,
    input  logic                     reset,
    input  logic [9:0]               BPM,
    input  logic [6:0]               Loops,
    input  logic                     Start,
    output logic                     step_tick,
    output logic [$clog2(STEPS)-1:0] step_index,
    output logic [6:0]               loop_count,
    output logic                     running,
    output logic                     done
);

    localparam int                IDX_W    = $clog2(STEPS);
    localparam longint            LIMIT_L  = longint'(CLK_HZ) * 60;
    localparam logic [34:0]       LIMIT    = 35'(LIMIT_L);
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(STEPS - 1);
    localparam logic [9:0]        BPM_LO   = 10'(MIN_BPM);
    localparam logic [9:0]        BPM_HI   = 10'(MAX_BPM);
    localparam logic [6:0]        LC_MAX   = 7'd127;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;

    logic               r_start_q;
    logic               r_armed;
    logic [33:0]        r_acc;
    logic [IDX_W-1:0]   r_idx;
    logic [6:0]         r_lc;
    logic [6:0]         r_loops;
    logic               r_tick;
    logic               r_done;
    logic               r_running;

    logic               w_start_edge;
    logic [9:0]         w_bpm_c;
    logic [34:0]        w_inc;
    logic [34:0]        w_sum;
    logic               w_boundary;
    logic [33:0]        w_acc_run;
    logic               w_last_step;
    logic [6:0]         w_lc_inc;
    logic [6:0]         w_lc_sat;
    logic               w_loops_hit;

    logic               w_tick_nxt;
    logic               w_done_nxt;
    logic [IDX_W-1:0]   w_idx_nxt;
    logic [6:0]         w_lc_nxt;
    logic [33:0]        w_acc_nxt;
    logic [6:0]         w_loops_nxt;

    // Start must be seen low at least once after reset before an edge counts,
    // so a Start level held high through reset release cannot launch a run.
    assign w_start_edge = Start & ~r_start_q & r_armed;

    assign w_bpm_c = (BPM < BPM_LO) ? BPM_LO :
                     (BPM > BPM_HI) ? BPM_HI : BPM;

    assign w_inc      = 35'(w_bpm_c) * 35'(STEPS_PER_BEAT);
    assign w_sum      = {1'b0, r_acc} + w_inc;
    assign w_boundary = (w_sum >= LIMIT);
    // Carry the remainder past LIMIT into the next step so rate error never accumulates.
    assign w_acc_run  = w_boundary ? 34'(w_sum - LIMIT) : 34'(w_sum);

    assign w_last_step = (r_idx == LAST_IDX);
    assign w_lc_inc    = r_lc + 7'd1;
    assign w_lc_sat    = (r_lc == LC_MAX) ? LC_MAX : w_lc_inc;
    assign w_loops_hit = (r_loops != 7'd0) && (w_lc_inc == r_loops);

    // ---------------------------------------------------------------- state register
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ---------------------------------------------------------------- next state
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_start_edge) begin
                    w_state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                if (w_start_edge) begin
                    w_state_nxt = S_IDLE;
                end else if (w_boundary && w_last_step && w_loops_hit) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // ---------------------------------------------------------------- outputs / datapath
    always_comb begin
        w_tick_nxt  = 1'b0;
        w_done_nxt  = 1'b0;
        w_idx_nxt   = r_idx;
        w_lc_nxt    = r_lc;
        w_acc_nxt   = r_acc;
        w_loops_nxt = r_loops;
        case (r_state)
            S_IDLE: begin
                if (w_start_edge) begin
                    w_tick_nxt  = 1'b1;
                    w_idx_nxt   = '0;
                    w_lc_nxt    = 7'd0;
                    w_acc_nxt   = 34'd0;
                    w_loops_nxt = Loops;
                end
            end
            S_RUN: begin
                // A stop edge freezes everything, even if a boundary lands on the same cycle.
                if (!w_start_edge) begin
                    w_acc_nxt = w_acc_run;
                    if (w_boundary) begin
                        if (!w_last_step) begin
                            w_idx_nxt  = r_idx + 1'b1;
                            w_tick_nxt = 1'b1;
                        end else begin
                            w_lc_nxt = w_lc_sat;
                            if (w_loops_hit) begin
                                w_done_nxt = 1'b1;
                            end else begin
                                w_idx_nxt  = '0;
                                w_tick_nxt = 1'b1;
                            end
                        end
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            r_start_q <= 1'b0;
            r_armed   <= 1'b0;
            r_acc     <= 34'd0;
            r_idx     <= '0;
            r_lc      <= 7'd0;
            r_loops   <= 7'd0;
            r_tick    <= 1'b0;
            r_done    <= 1'b0;
            r_running <= 1'b0;
        end else begin
            r_start_q <= Start;
            r_armed   <= r_armed | ~Start;
            r_acc     <= w_acc_nxt;
            r_idx     <= w_idx_nxt;
            r_lc      <= w_lc_nxt;
            r_loops   <= w_loops_nxt;
            r_tick    <= w_tick_nxt;
            r_done    <= w_done_nxt;
            r_running <= (w_state_nxt == S_RUN);
        end
    end

    assign step_tick  = r_tick;
    assign step_index = r_idx;
    assign loop_count = r_lc;
    assign running    = r_running;
    assign done       = r_done;

endmodule

// File: tb/tb_step_clock.sv
module tb_step_clock;

    localparam int CLK_HZ = 100;
    localparam int STEPS  = 4;
    localparam int SPB    = 1;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [9:0] bpm = 10'd60;
    logic [6:0] loops = 7'd0;
    logic       start = 1'b1;
    logic       tick;
    logic [1:0] idx;
    logic [6:0] lc;
    logic       run;
    logic       dn;

    int cyc = 0;
    int n_chk = 0;
    int n_fail = 0;

    typedef struct {
        bit is_done;
        int at;
        int idx;
        int lc;
    } ev_t;

    ev_t sb[$];

    step_clock #(
        .CLK_HZ(CLK_HZ), .STEPS(STEPS), .STEPS_PER_BEAT(SPB),
        .MIN_BPM(30), .MAX_BPM(300)
    ) dut (
        .CLOCK_50(clk), .reset(rst), .BPM(bpm), .Loops(loops), .Start(start),
        .step_tick(tick), .step_index(idx), .loop_count(lc),
        .running(run), .done(dn)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic push(input bit d, input int at, input int i, input int l);
        ev_t e;
        e.is_done = d;
        e.at = at;
        e.idx = i;
        e.lc = l;
        sb.push_back(e);
    endtask

    // Push n ticks of one step period, step k having index k%STEPS and loop k/STEPS.
    task automatic push_ticks(input int e0, input int period, input int n);
        for (int k = 0; k < n; k++)
            push(1'b0, e0 + period * k, k % STEPS, k / STEPS);
    endtask

    task automatic step();
        ev_t e;
        @(negedge clk);
        chk("tick_done_exclusive", int'(tick & dn), 0);
        if (tick || dn) begin
            chk("event_expected", int'(sb.size() != 0), 1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk("ev_cycle", cyc, e.at);
                chk("ev_is_done", int'(dn), int'(e.is_done));
                chk("ev_idx", int'(idx), e.idx);
                chk("ev_lc", int'(lc), e.lc);
            end
        end
    endtask

    task automatic run_to(input int target);
        while (cyc < target) step();
    endtask

    task automatic quiet(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic drain(input int budget);
        int n;
        n = 0;
        while (sb.size() != 0 && n < budget) begin
            step();
            n++;
        end
        chk("drain_pending", sb.size(), 0);
        sb.delete();
    endtask

    // Toggle Start low then high; returns the cycle of the active edge.
    task automatic pulse_start(output int e);
        start = 1'b0;
        step();
        start = 1'b1;
        e = cyc + 1;
    endtask

    initial begin
        int e;

        // T1: reset held with Start high
        rst = 1'b1; start = 1'b1; bpm = 10'd60; loops = 7'd0;
        quiet(3);
        chk("rst_tick", int'(tick), 0);
        chk("rst_idx", int'(idx), 0);
        chk("rst_lc", int'(lc), 0);
        chk("rst_running", int'(run), 0);
        chk("rst_done", int'(dn), 0);
        rst = 1'b0;
        quiet(30);
        chk("held_start_no_run", int'(run), 0);

        // T2: BPM 60, run forever, 100-cycle steps
        pulse_start(e);
        push_ticks(e, 100, 9);
        step();
        chk("t2_running", int'(run), 1);
        drain(1100);
        chk("t2_lc_after", int'(lc), 2);

        // T5: stop edge lands exactly on the next boundary cycle (e+900)
        start = 1'b0;
        run_to(e + 899);
        start = 1'b1;
        quiet(150);
        chk("t5_running", int'(run), 0);
        chk("t5_idx_held", int'(idx), 0);
        chk("t5_lc_held", int'(lc), 2);
        chk("t5_done", int'(dn), 0);

        // T4: Loops=2 -> 8 ticks then done; later Loops edit ignored
        loops = 7'd2;
        pulse_start(e);
        push_ticks(e, 100, 8);
        push(1'b1, e + 800, 3, 2);
        step();
        loops = 7'd5;
        drain(1000);
        chk("t4_running", int'(run), 0);
        chk("t4_lc", int'(lc), 2);
        chk("t4_idx", int'(idx), 3);
        quiet(150);
        chk("t4_still_idle", int'(run), 0);
        loops = 7'd0;

        // T3: clamps
        bpm = 10'd600;
        pulse_start(e);
        push_ticks(e, 20, 5);
        drain(200);
        start = 1'b0; step(); start = 1'b1;
        quiet(40);
        chk("t3_hi_stopped", int'(run), 0);

        bpm = 10'd0;
        pulse_start(e);
        push_ticks(e, 200, 3);
        drain(600);
        start = 1'b0; step(); start = 1'b1;
        quiet(250);
        chk("t3_lo_stopped", int'(run), 0);

        // T6: live tempo change mid-step
        bpm = 10'd60;
        pulse_start(e);
        push_ticks(e, 100, 2);
        drain(300);
        run_to(e + 130);
        bpm = 10'd120;
        push(1'b0, e + 165, 2, 0);
        push(1'b0, e + 215, 3, 0);
        push(1'b0, e + 265, 0, 1);
        drain(400);
        start = 1'b0; step(); start = 1'b1;
        quiet(80);

        // Reset mid-run: aborts, no done afterwards
        bpm = 10'd600; loops = 7'd1;
        pulse_start(e);
        push(1'b0, e, 0, 0);
        drain(10);
        run_to(e + 10);
        rst = 1'b1;
        step();
        chk("mid_rst_running", int'(run), 0);
        chk("mid_rst_idx", int'(idx), 0);
        chk("mid_rst_lc", int'(lc), 0);
        rst = 1'b0;
        quiet(120);
        chk("post_rst_running", int'(run), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
